pkt_loop_buf: RTL and testbench
===============================

Name: pkt_loop_buf

Overview:
- Single-clock, multi-packet store-and-forward buffer for the UDP loopback and flash-programming paths.
- Generalises the single-packet FIFO-plus-pulse scheme: configurable data width, depth and number of queued packets.
- Adds commit/abort on the write side, drop on overflow, and a per-packet read sequencer with start and done strobes.
- Sits between the UDP receive interface (already synchronised into sys_clk) and the UDP transmit or flash_rw consumer.

Parameters:
- DATA_W, 32: data word width in bits; must be a multiple of 8.
- DEPTH, 2048: data RAM depth in words; power of two.
- PKT_NUM, 4: maximum committed packets queued; power of two.
- ADDR_W, clog2(DEPTH): derived, not overridden.

Ports:
- sys_clk  in  1  sole clock.
- sys_rst_n  in  1  synchronous reset, active-low.
- wr_en  in  1  write one data word.
- wr_data  in  DATA_W  write word.
- wr_commit  in  1  pulse: close the current packet.
- wr_byte_num  in  16  byte count of the closing packet, sampled with wr_commit.
- wr_abort  in  1  pulse: discard the open packet.
- rd_req  in  1  read one word of the active packet.
- rd_data  out  DATA_W  read word, registered.
- pkt_start  out  1  one-cycle pulse: a packet became active.
- pkt_byte_num  out  16  byte count of the active packet, valid from pkt_start until rd_pkt_done.
- pkt_word_num  out  ADDR_W+1  word count of the active packet.
- rd_pkt_done  out  1  one-cycle pulse: active packet fully read.
- pkt_cnt  out  clog2(PKT_NUM)+1  committed packets queued, including the active one.
- drop_cnt  out  16  packets dropped; saturates at 16'hFFFF.

Behaviour:
- Reset (sys_rst_n low at a sys_clk edge):
  - Clears all pointers, the length queue, the FSM (to IDLE) and all outputs to 0.
  - Reset mid-packet loses all buffered and open data.
  - RAM contents need not clear.
- Write side: the write pointer wp, committed pointer cp and read pointer rp are each ADDR_W+1 bits.
  - wr_en stores wr_data at wp and increments wp, unless wp - rp == DEPTH; then the word is not stored and the open packet is flagged err.
  - wr_commit with err clear, at least one word, and pkt_cnt < PKT_NUM: cp <= wp; push {wr_byte_num, wp - cp} into the length queue; pkt_cnt increments.
  - wr_commit with err set, or with pkt_cnt == PKT_NUM: treated as abort (wp <= cp) and drop_cnt increments.
  - wr_commit with zero words: no effect, no drop counted.
  - wr_abort: wp <= cp, err cleared, no drop counted.
  - wr_commit or wr_abort clears err.
  - wr_en in the same cycle as wr_commit: the word belongs to the closing packet.
  - wr_abort and wr_commit together: abort wins.
- Read FSM:
  - IDLE: when the length queue is non-empty, go to START.
  - START: pkt_start = 1 for one cycle; latch pkt_byte_num and pkt_word_num from the queue head; remaining <= word count; go to READ.
  - READ: rd_req with remaining > 0 reads RAM[rp]; rd_data is valid on the next cycle; rp and remaining update. rd_req with remaining == 0 is ignored and rd_data holds. When remaining reaches 0, go to DONE.
  - DONE: pop the queue head; rd_pkt_done = 1 for one cycle; pkt_cnt decrements; return to IDLE.
  - Minimum gap from the last rd_req to the next pkt_start is 3 cycles.
- Simultaneous push (commit) and pop (DONE): pkt_cnt is unchanged; both queue entries stay correct.
- Space freed by reads is available to wr_en on the next cycle.
- Read and write at the same address in one cycle cannot occur, because reads only reach committed data.
- All pointer arithmetic wraps modulo 2^(ADDR_W+1); full is wp - rp == DEPTH; empty data is rp == cp.

Test Plan:
1. Write 4 words 0x11111111..0x44444444, commit with byte_num 16 -> pkt_start 2 cycles later with pkt_byte_num 16 and pkt_word_num 4; 4 rd_req return the same words with 1-cycle latency; rd_pkt_done one cycle after DONE entry; pkt_cnt 1 -> 0.
2. Commit 5 packets of 2 words with PKT_NUM 4 and no reads -> 5th dropped: drop_cnt 1, pkt_cnt 4; reading out yields packets 1-4 in order.
3. DEPTH 16: write 17 words then commit -> packet dropped, drop_cnt 1, pkt_cnt 0; next 3-word packet commits and reads back correctly.
4. Write 3 words, wr_abort, write 2 words 0xA, 0xB, commit 8 -> only 0xA, 0xB read; pkt_word_num 2; drop_cnt 0.
5. While reading packet 1, commit packet 2 in the same cycle as DONE -> pkt_cnt stays 1; packet 2 starts 2 cycles later with correct data across the RAM wrap point (rp crossing DEPTH-1 -> 0).
6. Assert sys_rst_n low mid-READ for 1 cycle -> all outputs 0, pkt_cnt 0; subsequent rd_req ignored until a new commit.

Source files
------------

// File: rtl/pkt_loop_buf.sv
// Multi-packet store-and-forward buffer: words are committed as whole packets, then replayed
// one packet at a time by a read sequencer that brackets each packet with start/done strobes.
module pkt_loop_buf #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned PKT_NUM = 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(PKT_NUM) + 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    input  logic [15:0]       wr_byte_num,
    input  logic              wr_abort,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              pkt_start,
    output logic [15:0]       pkt_byte_num,
    output logic [ADDR_W:0]   pkt_word_num,
    output logic              rd_pkt_done,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned     QA_W     = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PKT_NUM);

    typedef enum logic [1:0] {StIdle, StStart, StRead, StDone} state_e;

    logic [DATA_W-1:0] r_mem     [DEPTH];
    logic [15:0]       r_q_bytes [PKT_NUM];
    logic [ADDR_W:0]   r_q_words [PKT_NUM];

    logic [ADDR_W:0]   r_wp, r_cp, r_rp, r_remain;
    logic              r_err;
    logic [QA_W-1:0]   r_qwp, r_qrp;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [15:0]       r_drop_cnt, r_pkt_byte_num;
    logic [ADDR_W:0]   r_pkt_word_num;
    logic              r_pkt_start, r_rd_pkt_done;
    logic [DATA_W-1:0] r_rd_data;
    state_e            r_state;

    logic              w_full, w_wr_ok, w_err, w_push, w_drop, w_pop, w_rd_go;
    logic [ADDR_W:0]   w_wp_nxt, w_pkt_len;

    // A word written alongside wr_commit belongs to the closing packet, so length uses w_wp_nxt.
    assign w_full    = (r_wp - r_rp) == FULL_LVL;
    assign w_wr_ok   = wr_en && !w_full;
    assign w_wp_nxt  = r_wp + {{ADDR_W{1'b0}}, w_wr_ok};
    assign w_pkt_len = w_wp_nxt - r_cp;
    assign w_err     = r_err || (wr_en && w_full);
    assign w_push    = wr_commit && !wr_abort && (w_pkt_len != '0) && !w_err
                       && (r_pkt_cnt != CNT_MAX);
    assign w_drop    = wr_commit && !wr_abort && (w_pkt_len != '0)
                       && (w_err || (r_pkt_cnt == CNT_MAX));
    assign w_pop     = (r_state == StDone);
    assign w_rd_go   = (r_state == StRead) && rd_req && (r_remain != '0);

    always_ff @(posedge sys_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wp[ADDR_W-1:0]] <= wr_data;
        end
        if (w_push) begin
            r_q_bytes[r_qwp] <= wr_byte_num;
            r_q_words[r_qwp] <= w_pkt_len;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_wp       <= '0;
            r_cp       <= '0;
            r_err      <= 1'b0;
            r_qwp      <= '0;
            r_drop_cnt <= '0;
        end else if (wr_abort) begin
            r_wp  <= r_cp;
            r_err <= 1'b0;
        end else if (wr_commit) begin
            r_err <= 1'b0;
            if (w_push) begin
                r_wp  <= w_wp_nxt;
                r_cp  <= w_wp_nxt;
                r_qwp <= r_qwp + 1'b1;
            end else if (w_drop) begin
                r_wp <= r_cp;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else begin
                r_wp <= w_wp_nxt;
            end
        end else begin
            r_wp  <= w_wp_nxt;
            r_err <= w_err;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state        <= StIdle;
            r_rp           <= '0;
            r_remain       <= '0;
            r_qrp          <= '0;
            r_pkt_cnt      <= '0;
            r_pkt_start    <= 1'b0;
            r_rd_pkt_done  <= 1'b0;
            r_pkt_byte_num <= '0;
            r_pkt_word_num <= '0;
            r_rd_data      <= '0;
        end else begin
            r_pkt_start   <= 1'b0;
            r_rd_pkt_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (r_pkt_cnt != '0) begin
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    r_pkt_start    <= 1'b1;
                    r_pkt_byte_num <= r_q_bytes[r_qrp];
                    r_pkt_word_num <= r_q_words[r_qrp];
                    r_remain       <= r_q_words[r_qrp];
                    r_state        <= StRead;
                end
                StRead: begin
                    if (w_rd_go) begin
                        r_rd_data <= r_mem[r_rp[ADDR_W-1:0]];
                        r_rp      <= r_rp + 1'b1;
                        r_remain  <= r_remain - 1'b1;
                        if (r_remain == ONE_WORD) begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_rd_pkt_done <= 1'b1;
                    r_qrp         <= r_qrp + 1'b1;
                    r_state       <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
            // A same-cycle commit and pop leave the count unchanged.
            if (w_push && !w_pop) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_pkt_cnt <= r_pkt_cnt - 1'b1;
            end
        end
    end

    assign rd_data      = r_rd_data;
    assign pkt_start    = r_pkt_start;
    assign pkt_byte_num = r_pkt_byte_num;
    assign pkt_word_num = r_pkt_word_num;
    assign rd_pkt_done  = r_rd_pkt_done;
    assign pkt_cnt      = r_pkt_cnt;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_pkt_loop_buf.sv
// Scoreboard bench for pkt_loop_buf: committed words and packet lengths are queued as expected
// results when written, then popped and compared as the read sequencer replays them.
module tb_pkt_loop_buf;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned PKT_NUM = 4;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(PKT_NUM) + 1;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit;
    logic [15:0]       wr_byte_num;
    logic              wr_abort;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              pkt_start;
    logic [15:0]       pkt_byte_num;
    logic [ADDR_W:0]   pkt_word_num;
    logic              rd_pkt_done;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [15:0]       drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] sb_data [$];
    logic [31:0] open_q  [$];
    logic [15:0] sb_bytes[$];
    int          sb_words[$];

    pkt_loop_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PKT_NUM(PKT_NUM)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_commit   (wr_commit),
        .wr_byte_num (wr_byte_num),
        .wr_abort    (wr_abort),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .pkt_start   (pkt_start),
        .pkt_byte_num(pkt_byte_num),
        .pkt_word_num(pkt_word_num),
        .rd_pkt_done (rd_pkt_done),
        .pkt_cnt     (pkt_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset();
        sys_rst_n   = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        wr_commit   = 1'b0;
        wr_byte_num = '0;
        wr_abort    = 1'b0;
        rd_req      = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        sb_data.delete();
        open_q.delete();
        sb_bytes.delete();
        sb_words.delete();
    endtask

    task automatic wr_word(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        open_q.push_back(d);
    endtask

    // ok is the bench's own prediction of whether this commit is accepted.
    task automatic commit_pkt(input logic [15:0] b, input bit ok);
        wr_commit   = 1'b1;
        wr_byte_num = b;
        tick();
        wr_commit = 1'b0;
        if (ok) begin
            foreach (open_q[i]) sb_data.push_back(open_q[i]);
            sb_bytes.push_back(b);
            sb_words.push_back(open_q.size());
        end
        open_q.delete();
    endtask

    task automatic abort_pkt();
        wr_abort = 1'b1;
        tick();
        wr_abort = 1'b0;
        open_q.delete();
    endtask

    task automatic read_word(output logic [31:0] d);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        d = rd_data;
    endtask

    task automatic wait_start(output int n);
        bit seen = 1'b0;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                tick();
                if (pkt_start === 1'b1) begin
                    n    = i;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_done(output int n);
        bit seen = 1'b0;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                tick();
                if (rd_pkt_done === 1'b1) begin
                    n    = i;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        n_cmp++;
        if (pkt_cnt !== '0) begin
            n_fail++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt);
        end
        n_cmp++;
        if (drop_cnt !== '0) begin
            n_fail++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt);
        end
        n_cmp++;
        if ({pkt_start, rd_pkt_done} !== 2'b00) begin
            n_fail++; $display("FAIL rst_strobes: got %b want 00", {pkt_start, rd_pkt_done});
        end
        n_cmp++;
        if (rd_data !== '0 || pkt_byte_num !== '0 || pkt_word_num !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: got %h/%0d/%0d want 0/0/0",
                     rd_data, pkt_byte_num, pkt_word_num);
        end
    endtask

    task automatic test_single();
        logic [31:0] d, exp;
        logic [15:0] eb;
        int          ew, n;
        apply_reset();
        for (int i = 0; i < 4; i++) wr_word(32'h1111_1111 * 32'(i + 1));
        commit_pkt(16'd16, 1'b1);
        n_cmp++;
        if (pkt_cnt !== CNT_W'(1)) begin
            n_fail++; $display("FAIL t1_cnt_commit: got %0d want 1", pkt_cnt);
        end
        wait_start(n);
        n_cmp++;
        if (n !== 2) begin
            n_fail++; $display("FAIL t1_start_latency: got %0d want 2", n);
        end
        eb = sb_bytes.pop_front();
        ew = sb_words.pop_front();
        n_cmp++;
        if (pkt_byte_num !== eb || pkt_word_num !== (ADDR_W + 1)'(ew)) begin
            n_fail++;
            $display("FAIL t1_lens: got %0d/%0d want %0d/%0d", pkt_byte_num, pkt_word_num, eb, ew);
        end
        for (int i = 0; i < 4; i++) begin
            read_word(d);
            exp = sb_data.pop_front();
            n_cmp++;
            if (d !== exp) begin
                n_fail++; $display("FAIL t1_data[%0d]: got %h want %h", i, d, exp);
            end
        end
        n_cmp++;
        if (rd_pkt_done !== 1'b0 || pkt_cnt !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL t1_pre_done: got done=%b cnt=%0d want 0/1", rd_pkt_done, pkt_cnt);
        end
        wait_done(n);
        n_cmp++;
        if (n !== 1 || pkt_cnt !== '0) begin
            n_fail++; $display("FAIL t1_done: got lat=%0d cnt=%0d want 1/0", n, pkt_cnt);
        end
        tick();
        n_cmp++;
        if (rd_pkt_done !== 1'b0) begin
            n_fail++; $display("FAIL t1_done_pulse: got %b want 0", rd_pkt_done);
        end
    endtask

    task automatic test_pkt_overflow();
        logic [31:0] d, exp;
        logic [15:0] eb;
        int          ew, n;
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            wr_word(32'hA000_0000 | (32'(k) << 8));
            wr_word(32'hA000_0001 | (32'(k) << 8));
            commit_pkt(16'(k * 8), k < 5);
        end
        n_cmp++;
        if (drop_cnt !== 16'd1 || pkt_cnt !== CNT_W'(4)) begin
            n_fail++; $display("FAIL t2_counts: got drop=%0d cnt=%0d want 1/4", drop_cnt, pkt_cnt);
        end
        for (int k = 1; k <= 4; k++) begin
            // The first packet was already started while later packets were being written.
            if (k > 1) begin
                wait_start(n);
                n_cmp++;
                if (n !== 2) begin
                    n_fail++; $display("FAIL t2_gap[%0d]: got %0d want 2", k, n);
                end
            end
            eb = sb_bytes.pop_front();
            ew = sb_words.pop_front();
            n_cmp++;
            if (pkt_byte_num !== eb || pkt_word_num !== (ADDR_W + 1)'(ew)) begin
                n_fail++;
                $display("FAIL t2_lens[%0d]: got %0d/%0d want %0d/%0d",
                         k, pkt_byte_num, pkt_word_num, eb, ew);
            end
            for (int i = 0; i < ew; i++) begin
                read_word(d);
                exp = sb_data.pop_front();
                n_cmp++;
                if (d !== exp) begin
                    n_fail++; $display("FAIL t2_data[%0d.%0d]: got %h want %h", k, i, d, exp);
                end
            end
            wait_done(n);
            n_cmp++;
            if (n !== 1) begin
                n_fail++; $display("FAIL t2_done[%0d]: got %0d want 1", k, n);
            end
        end
        n_cmp++;
        if (pkt_cnt !== '0) begin
            n_fail++; $display("FAIL t2_cnt_end: got %0d want 0", pkt_cnt);
        end
    endtask

    task automatic test_data_overflow();
        logic [31:0] d, exp;
        int          n;
        bit          seen = 1'b0;
        apply_reset();
        for (int i = 0; i < 17; i++) wr_word(32'hC000_0000 + 32'(i));
        commit_pkt(16'd68, 1'b0);
        repeat (4) begin
            tick();
            if (pkt_start === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (drop_cnt !== 16'd1 || pkt_cnt !== '0 || seen) begin
            n_fail++;
            $display("FAIL t3_drop: got drop=%0d cnt=%0d start=%b want 1/0/0",
                     drop_cnt, pkt_cnt, seen);
        end
        for (int i = 0; i < 3; i++) wr_word(32'hD000_0000 + 32'(i));
        commit_pkt(16'd12, 1'b1);
        wait_start(n);
        n_cmp++;
        if (n !== 2 || pkt_word_num !== (ADDR_W + 1)'(sb_words.pop_front())
            || pkt_byte_num !== sb_bytes.pop_front()) begin
            n_fail++;
            $display("FAIL t3_start: got lat=%0d words=%0d bytes=%0d want 2/3/12",
                     n, pkt_word_num, pkt_byte_num);
        end
        for (int i = 0; i < 3; i++) begin
            read_word(d);
            exp = sb_data.pop_front();
            n_cmp++;
            if (d !== exp) begin
                n_fail++; $display("FAIL t3_data[%0d]: got %h want %h", i, d, exp);
            end
        end
        wait_done(n);
        n_cmp++;
        if (n !== 1 || pkt_cnt !== '0) begin
            n_fail++; $display("FAIL t3_done: got lat=%0d cnt=%0d want 1/0", n, pkt_cnt);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d, exp;
        int          n;
        apply_reset();
        for (int i = 0; i < 3; i++) wr_word(32'hEEEE_0000 + 32'(i));
        abort_pkt();
        wr_word(32'h0000_000A);
        wr_word(32'h0000_000B);
        commit_pkt(16'd8, 1'b1);
        wait_start(n);
        n_cmp++;
        if (n !== 2 || pkt_word_num !== (ADDR_W + 1)'(sb_words.pop_front())
            || pkt_byte_num !== sb_bytes.pop_front()) begin
            n_fail++;
            $display("FAIL t4_start: got lat=%0d words=%0d bytes=%0d want 2/2/8",
                     n, pkt_word_num, pkt_byte_num);
        end
        for (int i = 0; i < 2; i++) begin
            read_word(d);
            exp = sb_data.pop_front();
            n_cmp++;
            if (d !== exp) begin
                n_fail++; $display("FAIL t4_data[%0d]: got %h want %h", i, d, exp);
            end
        end
        wait_done(n);
        n_cmp++;
        if (n !== 1 || drop_cnt !== '0 || pkt_cnt !== '0) begin
            n_fail++;
            $display("FAIL t4_done: got lat=%0d drop=%0d cnt=%0d want 1/0/0",
                     n, drop_cnt, pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, exp;
        int          n;
        apply_reset();
        for (int i = 0; i < 12; i++) wr_word(32'h5000_0000 + 32'(i));
        commit_pkt(16'd48, 1'b1);
        wait_start(n);
        n_cmp++;
        if (n !== 2 || pkt_word_num !== (ADDR_W + 1)'(sb_words.pop_front())
            || pkt_byte_num !== sb_bytes.pop_front()) begin
            n_fail++;
            $display("FAIL t5_start1: got lat=%0d words=%0d bytes=%0d want 2/12/48",
                     n, pkt_word_num, pkt_byte_num);
        end
        for (int i = 0; i < 12; i++) begin
            // Packet 2 is written halfway through, landing across the RAM wrap point.
            if (i == 6) begin
                for (int j = 0; j < 6; j++) wr_word(32'h6000_0000 + 32'(j));
            end
            read_word(d);
            exp = sb_data.pop_front();
            n_cmp++;
            if (d !== exp) begin
                n_fail++; $display("FAIL t5_data1[%0d]: got %h want %h", i, d, exp);
            end
        end
        commit_pkt(16'd24, 1'b1);
        n_cmp++;
        if (rd_pkt_done !== 1'b1 || pkt_cnt !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL t5_push_pop: got done=%b cnt=%0d want 1/1", rd_pkt_done, pkt_cnt);
        end
        wait_start(n);
        n_cmp++;
        if (n !== 2 || pkt_word_num !== (ADDR_W + 1)'(sb_words.pop_front())
            || pkt_byte_num !== sb_bytes.pop_front()) begin
            n_fail++;
            $display("FAIL t5_start2: got lat=%0d words=%0d bytes=%0d want 2/6/24",
                     n, pkt_word_num, pkt_byte_num);
        end
        for (int i = 0; i < 6; i++) begin
            read_word(d);
            exp = sb_data.pop_front();
            n_cmp++;
            if (d !== exp) begin
                n_fail++; $display("FAIL t5_data2[%0d]: got %h want %h", i, d, exp);
            end
        end
        wait_done(n);
        n_cmp++;
        if (n !== 1 || pkt_cnt !== '0) begin
            n_fail++; $display("FAIL t5_done: got lat=%0d cnt=%0d want 1/0", n, pkt_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d, exp;
        int          n;
        bit          bad = 1'b0;
        apply_reset();
        for (int i = 0; i < 4; i++) wr_word(32'h7000_0000 + 32'(i));
        commit_pkt(16'd16, 1'b1);
        wait_start(n);
        void'(sb_words.pop_front());
        void'(sb_bytes.pop_front());
        read_word(d);
        exp = sb_data.pop_front();
        n_cmp++;
        if (d !== exp) begin
            n_fail++; $display("FAIL t6_first: got %h want %h", d, exp);
        end
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        sb_data.delete();
        sb_bytes.delete();
        sb_words.delete();
        n_cmp++;
        if (rd_data !== '0 || pkt_cnt !== '0 || pkt_byte_num !== '0 || pkt_word_num !== '0
            || pkt_start !== 1'b0 || rd_pkt_done !== 1'b0 || drop_cnt !== '0) begin
            n_fail++;
            $display("FAIL t6_reset: got data=%h cnt=%0d bytes=%0d words=%0d want all 0",
                     rd_data, pkt_cnt, pkt_byte_num, pkt_word_num);
        end
        rd_req = 1'b1;
        repeat (4) begin
            tick();
            if (rd_data !== '0 || pkt_start !== 1'b0) bad = 1'b1;
        end
        rd_req = 1'b0;
        n_cmp++;
        if (bad) begin
            n_fail++; $display("FAIL t6_ignored: got activity=1 want 0");
        end
        wr_word(32'h8000_0001);
        wr_word(32'h8000_0002);
        commit_pkt(16'd8, 1'b1);
        wait_start(n);
        n_cmp++;
        if (n !== 2 || pkt_word_num !== (ADDR_W + 1)'(sb_words.pop_front())
            || pkt_byte_num !== sb_bytes.pop_front()) begin
            n_fail++;
            $display("FAIL t6_start: got lat=%0d words=%0d bytes=%0d want 2/2/8",
                     n, pkt_word_num, pkt_byte_num);
        end
        for (int i = 0; i < 2; i++) begin
            read_word(d);
            exp = sb_data.pop_front();
            n_cmp++;
            if (d !== exp) begin
                n_fail++; $display("FAIL t6_data[%0d]: got %h want %h", i, d, exp);
            end
        end
        wait_done(n);
        n_cmp++;
        if (n !== 1) begin
            n_fail++; $display("FAIL t6_done: got %0d want 1", n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pkt_overflow();
        test_data_overflow();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
